// File: rtl/sha_256.sv
// SHA-256 engine for a fixed-length message. The message is padded internally, and each
// 512-bit block is compressed at one round per clock. The digest is held with a sticky done flag.
module sha_256 #(
  parameter int MSG_SIZE    = 24,
  parameter int PADDED_SIZE = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MSG_SIZE-1:0] message,
  output logic [255:0]        hashed,
  output logic                done
);

  localparam int N_BLK = PADDED_SIZE / 512;
  localparam int KW    = (N_BLK > 1) ? $clog2(N_BLK) : 1;

  localparam logic [7:0][31:0] H_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {LOAD, ROUND, UPDATE, DONE} state_t;

  state_t                 state;
  logic [KW-1:0]          blk;
  logic [5:0]             t;
  logic [PADDED_SIZE-1:0] padded_q;
  logic [PADDED_SIZE-1:0] padded_in;
  logic [PADDED_SIZE-1:0] blk_src;
  logic [511:0]           blk_data;
  logic [7:0][31:0]       h_q;
  logic [7:0][31:0]       v;
  logic [7:0][31:0]       v_next;
  logic [15:0][31:0]      w_win;
  logic [31:0]            w_new;
  logic [31:0]            t1;
  logic [31:0]            t2;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Padding: message, a single 1 bit, zero fill, then the 64-bit length in the last word pair.
  always_comb begin
    padded_in                                = '0;
    padded_in[PADDED_SIZE-1 -: MSG_SIZE]     = message;
    padded_in[PADDED_SIZE-1-MSG_SIZE]        = 1'b1;
    padded_in[63:0]                          = 64'(MSG_SIZE);
  end

  // Block 0 comes straight from the port so it can be loaded on the same edge as the capture.
  always_comb begin
    blk_src  = (blk == '0) ? padded_in : padded_q;
    blk_data = blk_src[PADDED_SIZE-1 -: 512];
    for (int i = 1; i < N_BLK; i++) begin
      if (blk == KW'(i)) blk_data = blk_src[PADDED_SIZE-1-512*i -: 512];
    end
  end

  // Round datapath: v[7..0] = a..h; the window head w_win[15] is W[t], and w_new is W[t+16].
  always_comb begin
    t1     = v[0] + big_sig1(v[3]) + ch(v[3], v[2], v[1]) + K_ROM[t] + w_win[15];
    t2     = big_sig0(v[7]) + maj(v[7], v[6], v[5]);
    v_next = {t1 + t2, v[7], v[6], v[5], v[4] + t1, v[3], v[2], v[1]};
    w_new  = sml_sig1(w_win[1]) + w_win[6] + sml_sig0(w_win[14]) + w_win[15];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= LOAD;
      blk    <= '0;
      t      <= '0;
      done   <= 1'b0;
      hashed <= '0;
      h_q    <= H_IV;
    end else begin
      case (state)
        LOAD: begin
          if (blk == '0) padded_q <= padded_in;
          v     <= h_q;
          w_win <= blk_data;
          t     <= '0;
          state <= ROUND;
        end
        ROUND: begin
          v     <= v_next;
          w_win <= {w_win[14:0], w_new};
          t     <= t + 6'd1;
          if (t == 6'd63) state <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v[i];
          if (blk == KW'(N_BLK - 1)) begin
            state <= DONE;
          end else begin
            blk   <= blk + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          done   <= 1'b1;
          hashed <= h_q;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_256.sv
// Bench for sha_256: known digests, done timing, capture, mid-run reset and boundary lengths
// against a small behavioural SHA-256 model.
module tb_sha_256;

  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIGEST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [0:63][31:0] KT = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [23:0]  msg_abc;
  logic [447:0] msg_two;
  logic [31:0]  msg_dave;
  logic [446:0] msg_b447;
  logic [255:0] hashed_abc, hashed_two, hashed_dave, hashed_b447;
  logic         done_abc, done_two, done_dave, done_b447;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sha_256 #(.MSG_SIZE(24),  .PADDED_SIZE(512))  u_abc  (.clk(clk), .rst(rst), .message(msg_abc),  .hashed(hashed_abc),  .done(done_abc));
  sha_256 #(.MSG_SIZE(448), .PADDED_SIZE(1024)) u_two  (.clk(clk), .rst(rst), .message(msg_two),  .hashed(hashed_two),  .done(done_two));
  sha_256 #(.MSG_SIZE(32),  .PADDED_SIZE(512))  u_dave (.clk(clk), .rst(rst), .message(msg_dave), .hashed(hashed_dave), .done(done_dave));
  sha_256 #(.MSG_SIZE(447), .PADDED_SIZE(512))  u_b447 (.clk(clk), .rst(rst), .message(msg_b447), .hashed(hashed_b447), .done(done_b447));

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 over the low len bits of m, first message bit at m[len-1].
  function automatic logic [255:0] sha_model(input logic [1023:0] m, input int len);
    logic [31:0]   hv [8];
    logic [31:0]   w  [64];
    logic [31:0]   a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    logic [1023:0] pad;
    logic [63:0]   len64;
    int            nb;
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    nb    = (len + 65 + 511) / 512;
    len64 = 64'(len);
    pad   = '0;
    for (int i = 0; i < len; i++) pad[1023-i] = m[len-1-i];
    pad[1023-len] = 1'b1;
    for (int i = 0; i < 64; i++) pad[1023-(nb*512-64)-i] = len64[63-i];
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 16; j++) w[j] = pad[1023-k*512-32*j -: 32];
      for (int j = 16; j < 64; j++) begin
        s0   = ror32(w[j-15], 7) ^ ror32(w[j-15], 18) ^ (w[j-15] >> 3);
        s1   = ror32(w[j-2], 17) ^ ror32(w[j-2], 19) ^ (w[j-2] >> 10);
        w[j] = w[j-16] + s0 + w[j-7] + s1;
      end
      a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
      e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
      for (int j = 0; j < 64; j++) begin
        t1 = h + (ror32(e, 6) ^ ror32(e, 11) ^ ror32(e, 25)) + ((e & f) ^ (~e & g)) + KT[j] + w[j];
        t2 = (ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1;
        d = c; c = b; b = a; a = t1 + t2;
      end
      hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
      hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    end
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [255:0] exp_dave, exp_b447, exp_abd, exp_rnd;
  logic [447:0] tmp;

  initial begin
    msg_abc  = "abc";
    msg_two  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    msg_dave = "Dave";
    for (int i = 0; i < 14; i++) tmp[i*32 +: 32] = $urandom;
    msg_b447 = tmp[446:0];
    exp_dave = sha_model(1024'(msg_dave), 32);
    exp_b447 = sha_model(1024'(msg_b447), 447);
    exp_abd  = sha_model(1024'(24'h616264), 24);

    // Reset held low
    repeat (3) tick();
    chk("rst_done_abc", 256'(done_abc), 256'(0));
    chk("rst_hash_abc", hashed_abc, '0);
    chk("rst_done_two", 256'(done_two), 256'(0));
    chk("rst_hash_two", hashed_two, '0);

    // Run 1: edge e is the e-th rising edge with rst high
    rst = 1'b1;
    for (int e = 1; e <= 167; e++) begin
      tick();
      if (e < 67) msg_abc = 24'($urandom);
      if (e == 1) chk("abc_done_e1", 256'(done_abc), 256'(0));
      if (e == 66) begin
        chk("abc_done_e66", 256'(done_abc), 256'(0));
        chk("abc_hash_e66", hashed_abc, '0);
        chk("b447_done_e66", 256'(done_b447), 256'(0));
        chk("dave_done_e66", 256'(done_dave), 256'(0));
      end
      if (e == 67) begin
        chk("abc_done_e67", 256'(done_abc), 256'(1));
        chk("abc_hash", hashed_abc, ABC_DIGEST);
        chk("b447_done_e67", 256'(done_b447), 256'(1));
        chk("b447_hash", hashed_b447, exp_b447);
        chk("dave_done_e67", 256'(done_dave), 256'(1));
        chk("dave_hash", hashed_dave, exp_dave);
      end
      if (e == 132) begin
        chk("two_done_e132", 256'(done_two), 256'(0));
        chk("two_hash_e132", hashed_two, '0);
      end
      if (e == 133) begin
        chk("two_done_e133", 256'(done_two), 256'(1));
        chk("two_hash", hashed_two, TWO_DIGEST);
      end
      if (e >= 68) begin
        chk("dave_hash_hold", hashed_dave, exp_dave);
        chk("dave_done_hold", 256'(done_dave), 256'(1));
      end
    end

    // Run 2: reset after completion, then abort mid-run with a new message
    rst     = 1'b0;
    msg_abc = "abc";
    for (int i = 0; i < 14; i++) tmp[i*32 +: 32] = $urandom;
    msg_two = tmp;
    exp_rnd = sha_model(1024'(msg_two), 448);
    tick();
    chk("rst2_done_abc", 256'(done_abc), 256'(0));
    chk("rst2_hash_abc", hashed_abc, '0);
    rst = 1'b1;
    repeat (29) tick();
    rst     = 1'b0;
    msg_abc = "abd";
    tick();
    chk("midrst_done_abc", 256'(done_abc), 256'(0));
    chk("midrst_hash_abc", hashed_abc, '0);
    rst = 1'b1;
    for (int e = 1; e <= 133; e++) begin
      tick();
      if (e <= 66) chk("abd_done_early", 256'(done_abc), 256'(0));
      if (e == 67) begin
        chk("abd_done_e67", 256'(done_abc), 256'(1));
        chk("abd_hash", hashed_abc, exp_abd);
      end
      if (e == 132) chk("rnd448_done_e132", 256'(done_two), 256'(0));
      if (e == 133) begin
        chk("rnd448_done_e133", 256'(done_two), 256'(1));
        chk("rnd448_hash", hashed_two, exp_rnd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
